masked_inv_sbox_d1: RTL

MASKED_INV_SBOX_D1 -- requirements
Module: masked_inv_sbox_d1

---
 rtl/masked_sbox_pkg.sv | 49 ++++
 rtl/masked_gf256_inv_d1.sv | 83 ++++++++
 rtl/masked_inv_sbox_d1.sv | 110 +++++++++++
 3 files changed

// File: rtl/masked_sbox_pkg.sv
// rtl/masked_sbox_pkg.sv - shared types, constants and GF(2^8) helpers for the masked inverse S-box
package masked_sbox_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;
  localparam int CNT_W       = 3;

  // Row i (bits [8i+7:8i]) selects the input bits XORed into output bit i.
  localparam logic [63:0] INV_AFFINE_M = 64'h5229_944A_2592_49A4;
  localparam logic [7:0]  SHARE_CONST  = 8'h05;

  function automatic logic [7:0] inv_affine_lin(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[i] = ^(x & INV_AFFINE_M[i*8 +: 8]);
    end
    return y;
  endfunction

  // Multiplication modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow2k(input logic [7:0] x, input int k);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < k; i++) begin
      y = gf_mul(y, y);
    end
    return y;
  endfunction

endpackage

// File: rtl/masked_gf256_inv_d1.sv
// rtl/masked_gf256_inv_d1.sv - two-share GF(2^8) inversion (x^254) with LATENCY output register stages
module masked_gf256_inv_d1
  import masked_sbox_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int FRESH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [7:0]         a_s0,
  input  logic [7:0]         a_s1,
  input  logic [FRESH_W-1:0] fresh,
  output logic [7:0]         z_s0,
  output logic [7:0]         z_s1
);

  logic [7:0] r_byte;
  logic [7:0] r1, r2, r3, r4, r5;
  logic [7:0] x2_s0, x2_s1, x2r_s0, x2r_s1;
  logic [7:0] x3_s0, x3_s1, x12_s0, x12_s1;
  logic [7:0] x15_s0, x15_s1, x240_s0, x240_s1;
  logic [7:0] x252_s0, x252_s1, x254_s0, x254_s1;
  logic [7:0] stg_s0 [LATENCY];
  logic [7:0] stg_s1 [LATENCY];

  always_comb begin
    r_byte = '0;
    for (int i = 0; i < 8; i++) begin
      r_byte[i] = fresh[i % FRESH_W];
    end
  end

  assign r1 = r_byte;
  assign r2 = {r_byte[6:0], r_byte[7]};
  assign r3 = {r_byte[4:0], r_byte[7:5]};
  assign r4 = {r_byte[2:0], r_byte[7:3]};
  assign r5 = {r_byte[0], r_byte[7:1]};

  // Two-share ISW product: each cross term is masked by r before it meets a share.
  function automatic logic [15:0] sec_mul(input logic [7:0] p0, input logic [7:0] p1,
                                          input logic [7:0] q0, input logic [7:0] q1,
                                          input logic [7:0] r);
    logic [7:0] m0, m1;
    m0 = gf_mul(p0, q0) ^ (gf_mul(p0, q1) ^ r);
    m1 = gf_mul(p1, q1) ^ (gf_mul(p1, q0) ^ r);
    return {m0, m1};
  endfunction

  // Squaring is linear, so it runs share-wise; x^2 is refreshed before it multiplies x.
  assign x2_s0  = gf_pow2k(a_s0, 1);
  assign x2_s1  = gf_pow2k(a_s1, 1);
  assign x2r_s0 = x2_s0 ^ r5;
  assign x2r_s1 = x2_s1 ^ r5;
  assign {x3_s0, x3_s1}     = sec_mul(x2r_s0, x2r_s1, a_s0, a_s1, r1);
  assign x12_s0 = gf_pow2k(x3_s0, 2);
  assign x12_s1 = gf_pow2k(x3_s1, 2);
  assign {x15_s0, x15_s1}   = sec_mul(x12_s0, x12_s1, x3_s0, x3_s1, r2);
  assign x240_s0 = gf_pow2k(x15_s0, 4);
  assign x240_s1 = gf_pow2k(x15_s1, 4);
  assign {x252_s0, x252_s1} = sec_mul(x240_s0, x240_s1, x12_s0, x12_s1, r3);
  assign {x254_s0, x254_s1} = sec_mul(x252_s0, x252_s1, x2_s0, x2_s1, r4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg_s0[i] <= '0;
        stg_s1[i] <= '0;
      end
    end else if (en) begin
      stg_s0[0] <= x254_s0;
      stg_s1[0] <= x254_s1;
      for (int i = 1; i < LATENCY; i++) begin
        stg_s0[i] <= stg_s0[i-1];
        stg_s1[i] <= stg_s1[i-1];
      end
    end
  end

  assign z_s0 = stg_s0[LATENCY-1];
  assign z_s1 = stg_s1[LATENCY-1];

endmodule

// File: rtl/masked_inv_sbox_d1.sv
// rtl/masked_inv_sbox_d1.sv - first-order masked AES inverse S-box with request/result handshake
// Macro CLOCK_GATING_EN: core and output registers run on a latch-based gated clock.
module masked_inv_sbox_d1
  import masked_sbox_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int FRESH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         X_s0,
  input  logic [7:0]         X_s1,
  input  logic [FRESH_W-1:0] Fresh,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         Y_s0,
  output logic [7:0]         Y_s1,
  output logic               Synch,
  input  logic               out_ready
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_check
    $error("masked_inv_sbox_d1: LATENCY out of range");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         x0_q, x1_q;
  logic [FRESH_W-1:0] fresh_q;
  logic [7:0]         a_s0, a_s1, z_s0, z_s1;
  logic               busy, accept, load_y;
  logic               core_clk, core_en;

  assign busy     = (state_q == S_BUSY);
  assign accept   = (state_q == S_IDLE) && in_valid;
  assign load_y   = busy && (cnt_q == '0);
  assign in_ready = (state_q == S_IDLE);
  assign Synch    = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)      state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0)   state_d = S_DONE;
      S_DONE:  if (out_ready)     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      fresh_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x0_q    <= X_s0;
        x1_q    <= X_s1;
        fresh_q <= Fresh;
        cnt_q   <= CNT_W'(LATENCY);
      end else if (busy && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Inverse affine map is linear, so each share is mapped on its own; the constant goes to share 0.
  assign a_s0 = inv_affine_lin(x0_q) ^ SHARE_CONST;
  assign a_s1 = inv_affine_lin(x1_q);

`ifdef CLOCK_GATING_EN
  logic icg_en_l;
  always_latch begin
    if (!clk) icg_en_l <= busy;
  end
  assign core_clk = clk & icg_en_l;
  assign core_en  = 1'b1;
`else
  assign core_clk = clk;
  assign core_en  = busy;
`endif

  masked_gf256_inv_d1 #(
    .LATENCY (LATENCY),
    .FRESH_W (FRESH_W)
  ) u_core (
    .clk   (core_clk),
    .rst_n (rst),
    .en    (core_en),
    .a_s0  (a_s0),
    .a_s1  (a_s1),
    .fresh (fresh_q),
    .z_s0  (z_s0),
    .z_s1  (z_s1)
  );

  always_ff @(posedge core_clk or negedge rst) begin
    if (!rst) begin
      Y_s0 <= '0;
      Y_s1 <= '0;
    end else if (load_y) begin
      Y_s0 <= z_s0;
      Y_s1 <= z_s1;
    end
  end

endmodule
